// File: rtl/frame_dump_ctrl.sv
// Producer side of the simulation dump interface: frame counting, dump window
// control and per-frame line/pixel measurement from the game video syncs.
module frame_dump_ctrl #(
    parameter logic [31:0] START_FRAME = 32'd0,
    parameter logic [31:0] DUMP_FRAMES = 32'd0,
    parameter int          LW          = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          vs,
    input  logic          hs,
    input  logic          downloading,
    output logic [31:0]   frame_cnt,
    output logic          frame_pulse,
    output logic          dump_en,
    output logic          dump_start,
    output logic          dump_stop,
    output logic [LW-1:0] vlines,
    output logic [LW-1:0] hpixels
);

    typedef enum logic [1:0] {WAIT_DL, ARMED, DUMP, DONE} state_t;

    localparam logic [LW-1:0] CNT_MAX = '1;

    state_t        state_q, state_d;
    logic          vs_hist_q, vs_hist_d;
    logic          hs_hist_q, hs_hist_d;
    logic [31:0]   frame_cnt_q, frame_cnt_d;
    logic          frame_pulse_q, frame_pulse_d;
    logic          dump_en_q, dump_en_d;
    logic          dump_start_q, dump_start_d;
    logic          dump_stop_q, dump_stop_d;
    logic [31:0]   dump_cnt_q, dump_cnt_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [LW-1:0] vlines_q, vlines_d;
    logic [LW-1:0] pix_cnt_q, pix_cnt_d;
    logic [LW-1:0] hpixels_q, hpixels_d;

    logic          vs_fall;
    logic          hs_fall;
    logic [31:0]   dump_cnt_inc;

    assign vs_fall      = pxl_cen & vs_hist_q & ~vs;
    assign hs_fall      = pxl_cen & hs_hist_q & ~hs;
    assign dump_cnt_inc = dump_cnt_q + 32'd1;

    always_comb begin
        state_d       = state_q;
        vs_hist_d     = vs_hist_q;
        hs_hist_d     = hs_hist_q;
        frame_cnt_d   = frame_cnt_q;
        frame_pulse_d = 1'b0;
        dump_en_d     = dump_en_q;
        dump_start_d  = 1'b0;
        dump_stop_d   = 1'b0;
        dump_cnt_d    = dump_cnt_q;
        line_cnt_d    = line_cnt_q;
        vlines_d      = vlines_q;
        pix_cnt_d     = pix_cnt_q;
        hpixels_d     = hpixels_q;

        if (pxl_cen) begin
            vs_hist_d = vs;
            hs_hist_d = hs;
        end

        if (vs_fall) begin
            frame_pulse_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 32'd1;
        end
        if (downloading) begin
            frame_cnt_d = 32'd0;
        end

        // A frame boundary that coincides with a line boundary starts the new frame at line 1
        if (vs_fall) begin
            vlines_d   = line_cnt_q;
            line_cnt_d = hs_fall ? LW'(1) : '0;
        end else if (hs_fall && line_cnt_q != CNT_MAX) begin
            line_cnt_d = line_cnt_q + LW'(1);
        end

        if (hs_fall) begin
            hpixels_d = (pix_cnt_q == CNT_MAX) ? CNT_MAX : pix_cnt_q + LW'(1);
            pix_cnt_d = '0;
        end else if (pxl_cen && pix_cnt_q != CNT_MAX) begin
            pix_cnt_d = pix_cnt_q + LW'(1);
        end

        // A download restarts the whole sequence and overrides any frame-boundary decision
        if (downloading) begin
            state_d = WAIT_DL;
            if (state_q == DUMP) begin
                dump_en_d   = 1'b0;
                dump_stop_d = 1'b1;
            end
        end else begin
            case (state_q)
                WAIT_DL: state_d = ARMED;
                ARMED: begin
                    if (vs_fall && frame_cnt_q == START_FRAME) begin
                        state_d      = DUMP;
                        dump_en_d    = 1'b1;
                        dump_start_d = 1'b1;
                        dump_cnt_d   = 32'd0;
                    end
                end
                DUMP: begin
                    if (vs_fall) begin
                        dump_cnt_d = dump_cnt_inc;
                        if (DUMP_FRAMES != 32'd0 && dump_cnt_inc == DUMP_FRAMES) begin
                            state_d     = DONE;
                            dump_en_d   = 1'b0;
                            dump_stop_d = 1'b1;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = WAIT_DL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_DL;
            vs_hist_q     <= 1'b0;
            hs_hist_q     <= 1'b0;
            frame_cnt_q   <= 32'd0;
            frame_pulse_q <= 1'b0;
            dump_en_q     <= 1'b0;
            dump_start_q  <= 1'b0;
            dump_stop_q   <= 1'b0;
            dump_cnt_q    <= 32'd0;
            line_cnt_q    <= '0;
            vlines_q      <= '0;
            pix_cnt_q     <= '0;
            hpixels_q     <= '0;
        end else begin
            state_q       <= state_d;
            vs_hist_q     <= vs_hist_d;
            hs_hist_q     <= hs_hist_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_pulse_q <= frame_pulse_d;
            dump_en_q     <= dump_en_d;
            dump_start_q  <= dump_start_d;
            dump_stop_q   <= dump_stop_d;
            dump_cnt_q    <= dump_cnt_d;
            line_cnt_q    <= line_cnt_d;
            vlines_q      <= vlines_d;
            pix_cnt_q     <= pix_cnt_d;
            hpixels_q     <= hpixels_d;
        end
    end

    assign frame_cnt   = frame_cnt_q;
    assign frame_pulse = frame_pulse_q;
    assign dump_en     = dump_en_q;
    assign dump_start  = dump_start_q;
    assign dump_stop   = dump_stop_q;
    assign vlines      = vlines_q;
    assign hpixels     = hpixels_q;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Bench for frame_dump_ctrl: one instance exercises the dump window, a second
// narrow-counter instance exercises measurement saturation and a one-frame window.
module tb_frame_dump_ctrl;

    localparam logic [31:0] START_A = 32'd2;
    localparam logic [31:0] DUMP_A  = 32'd3;

    typedef struct {
        logic [31:0] cnt;
        logic        start;
        logic        stop;
        logic        en;
    } exp_t;

    typedef struct {
        int         ppl;
        int         lpf;
        logic [2:0] exp_vl;
        logic [2:0] exp_hp;
    } vec_t;

    logic clk = 1'b0;
    logic rst, pxl_cen, vs, hs, downloading_a, downloading_b, sel_b;
    logic pxl_cen_a, pxl_cen_b;

    logic [31:0] frame_cnt_a, frame_cnt_b;
    logic        frame_pulse_a, dump_en_a, dump_start_a, dump_stop_a;
    logic        frame_pulse_b, dump_en_b, dump_start_b, dump_stop_b;
    logic [9:0]  vlines_a, hpixels_a;
    logic [2:0]  vlines_b, hpixels_b;

    int total = 0;
    int bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    int start_seen = 0, stop_seen = 0;
    int b_starts = 0, b_stops = 0;
    logic [31:0] b_start_at = '0, b_stop_at = '0;

    logic [31:0] m_cnt;
    logic        m_armed, m_dump;
    logic [31:0] m_n;

    vec_t vecs[5];

    assign pxl_cen_a = pxl_cen & ~sel_b;
    assign pxl_cen_b = pxl_cen & sel_b;

    always #5 clk = ~clk;

    frame_dump_ctrl #(.START_FRAME(START_A), .DUMP_FRAMES(DUMP_A), .LW(10)) dut_a (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen_a), .vs(vs), .hs(hs),
        .downloading(downloading_a), .frame_cnt(frame_cnt_a), .frame_pulse(frame_pulse_a),
        .dump_en(dump_en_a), .dump_start(dump_start_a), .dump_stop(dump_stop_a),
        .vlines(vlines_a), .hpixels(hpixels_a)
    );

    frame_dump_ctrl #(.START_FRAME(32'd0), .DUMP_FRAMES(32'd1), .LW(3)) dut_b (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen_b), .vs(vs), .hs(hs),
        .downloading(downloading_b), .frame_cnt(frame_cnt_b), .frame_pulse(frame_pulse_b),
        .dump_en(dump_en_b), .dump_start(dump_start_b), .dump_stop(dump_stop_b),
        .vlines(vlines_b), .hpixels(hpixels_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected outcome of one frame boundary on instance A
    task automatic modelBoundary();
        exp_t e;
        logic [31:0] pre;
        e.start = 1'b0;
        e.stop  = 1'b0;
        if (downloading_a) begin
            m_cnt = 32'd0;
        end else begin
            pre   = m_cnt;
            m_cnt = pre + 32'd1;
            if (m_armed && pre == START_A) begin
                m_armed = 1'b0;
                m_dump  = 1'b1;
                m_n     = 32'd0;
                e.start = 1'b1;
            end else if (m_dump) begin
                m_n = m_n + 32'd1;
                if (m_n == DUMP_A) begin
                    m_dump = 1'b0;
                    e.stop = 1'b1;
                end
            end
        end
        e.cnt = m_cnt;
        e.en  = m_dump;
        sb.push_back(e);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pxl_cen = 1'b0;
        end
    endtask

    // hs high on pixel 0 of each line, vs high on pixel 0 of line 0: both fall on pixel 1
    task automatic applyStimulus(input int frames, input int ppl, input int lpf, input bit gap);
        for (int f = 0; f < frames; f++) begin
            for (int l = 0; l < lpf; l++) begin
                for (int p = 0; p < ppl; p++) begin
                    if (gap && l == 2 && p == 3) begin
                        for (int g = 0; g < 50; g++) begin
                            @(posedge clk); #1;
                            pxl_cen = 1'b0;
                        end
                    end
                    @(posedge clk); #1;
                    pxl_cen = 1'b1;
                    hs = (p == 0);
                    vs = (p == 0) && (l == 0);
                    if (!sel_b && l == 0 && p == 1) modelBoundary();
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_pulse_a) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb_underflow: actual=frame_pulse required=no pulse");
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("sb_frame_cnt", frame_cnt_a, mon_e.cnt);
                    checkOutput("sb_dump_start", {31'd0, dump_start_a}, {31'd0, mon_e.start});
                    checkOutput("sb_dump_stop", {31'd0, dump_stop_a}, {31'd0, mon_e.stop});
                    checkOutput("sb_dump_en", {31'd0, dump_en_a}, {31'd0, mon_e.en});
                end
            end
            if (dump_start_a) start_seen++;
            if (dump_stop_a) stop_seen++;
            if (dump_start_a || dump_stop_a)
                checkOutput("start_stop_excl", {31'd0, dump_start_a & dump_stop_a}, 32'd0);
            if (dump_start_b) begin b_starts++; b_start_at = frame_cnt_b; end
            if (dump_stop_b) begin b_stops++; b_stop_at = frame_cnt_b; end
        end
    end

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_frame_cnt"}, frame_cnt_a, 32'd0);
        checkOutput({tag, "_frame_pulse"}, {31'd0, frame_pulse_a}, 32'd0);
        checkOutput({tag, "_dump_en"}, {31'd0, dump_en_a}, 32'd0);
        checkOutput({tag, "_dump_start"}, {31'd0, dump_start_a}, 32'd0);
        checkOutput({tag, "_dump_stop"}, {31'd0, dump_stop_a}, 32'd0);
        checkOutput({tag, "_vlines"}, {22'd0, vlines_a}, 32'd0);
        checkOutput({tag, "_hpixels"}, {22'd0, hpixels_a}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{ppl: 8, lpf: 6,  exp_vl: 3'd6, exp_hp: 3'd7};
        vecs[1] = '{ppl: 5, lpf: 4,  exp_vl: 3'd4, exp_hp: 3'd5};
        vecs[2] = '{ppl: 4, lpf: 10, exp_vl: 3'd7, exp_hp: 3'd4};
        vecs[3] = '{ppl: 7, lpf: 7,  exp_vl: 3'd7, exp_hp: 3'd7};
        vecs[4] = '{ppl: 3, lpf: 2,  exp_vl: 3'd2, exp_hp: 3'd3};

        rst = 1'b1; pxl_cen = 1'b0; vs = 1'b0; hs = 1'b0; sel_b = 1'b0;
        downloading_a = 1'b0; downloading_b = 1'b0;
        m_cnt = 32'd0; m_armed = 1'b1; m_dump = 1'b0; m_n = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkResetA("reset");

        // Seven frames: window opens on the 3rd boundary, closes on the 6th
        applyStimulus(7, 8, 6, 1'b0);
        idleCycles(1);
        @(negedge clk);
        checkOutput("run1_vlines", {22'd0, vlines_a}, 32'd6);
        checkOutput("run1_hpixels", {22'd0, hpixels_a}, 32'd8);
        checkOutput("run1_frame_cnt", frame_cnt_a, 32'd7);
        checkOutput("run1_dump_en", {31'd0, dump_en_a}, 32'd0);

        // Download while DONE: no stop pulse
        @(posedge clk); #1;
        downloading_a = 1'b1;
        m_cnt = 32'd0; m_armed = 1'b0; m_dump = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("dl_done_stop", {31'd0, dump_stop_a}, 32'd0);
        checkOutput("dl_done_frame_cnt", frame_cnt_a, 32'd0);
        @(posedge clk); #1;
        downloading_a = 1'b0;
        m_armed = 1'b1;
        idleCycles(2);

        // Reopen, then download mid-dump
        applyStimulus(4, 8, 6, 1'b0);
        @(posedge clk); #1;
        pxl_cen = 1'b0;
        downloading_a = 1'b1;
        m_cnt = 32'd0; m_armed = 1'b0; m_dump = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("dl_dump_stop", {31'd0, dump_stop_a}, 32'd1);
        checkOutput("dl_dump_en", {31'd0, dump_en_a}, 32'd0);
        checkOutput("dl_frame_cnt", frame_cnt_a, 32'd0);
        @(negedge clk);
        checkOutput("dl_stop_once", {31'd0, dump_stop_a}, 32'd0);
        applyStimulus(4, 8, 6, 1'b0);
        idleCycles(1);
        @(negedge clk);
        checkOutput("dl_hold_frame_cnt", frame_cnt_a, 32'd0);

        // Release download; reopen with a 50-clk pxl_cen gap inside each frame
        @(posedge clk); #1;
        downloading_a = 1'b0;
        m_armed = 1'b1;
        idleCycles(2);
        applyStimulus(4, 8, 6, 1'b1);
        idleCycles(1);
        @(negedge clk);
        checkOutput("gap_hpixels", {22'd0, hpixels_a}, 32'd8);
        checkOutput("gap_vlines", {22'd0, vlines_a}, 32'd6);
        checkOutput("gap_dump_en", {31'd0, dump_en_a}, 32'd1);
        checkOutput("gap_frame_cnt", frame_cnt_a, 32'd4);

        // Reset mid-dump: everything back to zero, no stop pulse
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetA("midrst");
        checkOutput("sb_empty", sb.size(), 32'd0);
        checkOutput("start_pulses", start_seen, 32'd3);
        checkOutput("stop_pulses", stop_seen, 32'd2);
        @(posedge clk); #1;
        rst = 1'b0;
        sel_b = 1'b1;
        idleCycles(2);

        // Narrow counters: saturation and coincident frame/line restart
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2, vecs[i].ppl, vecs[i].lpf, 1'b0);
            idleCycles(1);
            @(negedge clk);
            checkOutput($sformatf("tbl%0d_vlines", i), {29'd0, vlines_b}, {29'd0, vecs[i].exp_vl});
            checkOutput($sformatf("tbl%0d_hpixels", i), {29'd0, hpixels_b}, {29'd0, vecs[i].exp_hp});
        end
        checkOutput("b_frame_cnt", frame_cnt_b, 32'd10);
        checkOutput("b_start_count", b_starts, 32'd1);
        checkOutput("b_stop_count", b_stops, 32'd1);
        checkOutput("b_start_at", b_start_at, 32'd1);
        checkOutput("b_stop_at", b_stop_at, 32'd2);
        checkOutput("b_dump_en", {31'd0, dump_en_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_dump_ctrl.md
Name: frame_dump_ctrl

Overview:
- Synthesizable producer side of the simulation dump interface.
- Watches the game video syncs and the ROM-download flag, and generates:
  - the running frame counter;
  - the dump-window enable and its start/stop pulses;
  - the measured line and pixel counts per frame.
- Sits between the video timing generator and the test-bench dump/monitor logic, so dump windows are decided in RTL rather than in bench code.

Parameters:
- START_FRAME, 0, frame_cnt value at whose frame boundary dumping begins.
- DUMP_FRAMES, 0, number of frames to dump; 0 = dump until reset/download.
- LW, 10, width of line and pixel measurement counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pxl_cen  in  1  pixel clock enable; syncs are sampled only when high.
- vs  in  1  vertical sync, active high; frame boundary = falling edge.
- hs  in  1  horizontal sync, active high; line boundary = falling edge.
- downloading  in  1  ROM download in progress (LED signal).
- frame_cnt  out  32  frames since download end/reset.
- frame_pulse  out  1  one clk cycle per frame boundary.
- dump_en  out  1  dump window active.
- dump_start  out  1  one-cycle pulse on window open.
- dump_stop  out  1  one-cycle pulse on window close.
- vlines  out  LW  hs falling edges counted in last complete frame.
- hpixels  out  LW  pxl_cen cycles in last complete line.

Behaviour:
- Reset values: frame_cnt=0, frame_pulse=0, dump_en=0, dump_start=0, dump_stop=0, vlines=0, hpixels=0, sync history regs=0, all internal counters=0.
- Edge detection:
  - On a clk with pxl_cen=1, vs/hs are sampled into history regs.
  - A falling edge is history=1 and current sample=0 on a pxl_cen cycle.
  - Registered outputs change on the next clk edge, so latency is 1 clk from the sampling cycle.
  - With pxl_cen=0, nothing samples and the pixel counter holds.
- frame_cnt:
  - +1 on every frame boundary, wraps 2^32-1 -> 0.
  - Held at 0 while downloading=1.
- frame_pulse: high exactly on the cycle frame_cnt updates. It also pulses while downloading (frame_cnt stays 0).
- Line measurement:
  - Line counter +1 (saturating at 2^LW-1) per hs falling edge.
  - At a frame boundary, vlines <= line counter and the counter clears to 0. If hs falls in the same sample, the counter loads 1.
- Pixel measurement:
  - Pixel counter +1 (saturating) per pxl_cen.
  - On an hs falling edge, hpixels <= pixel counter + 1 (saturating) and the counter clears to 0.
- FSM states: WAIT_DL, ARMED, DUMP, DONE. Reset state is WAIT_DL.
  - WAIT_DL: leave when downloading=0 -> ARMED. This applies immediately after reset if downloading is already 0, giving 1 clk in WAIT_DL.
  - ARMED: at a frame boundary where pre-increment frame_cnt == START_FRAME -> DUMP. dump_en<=1 and dump_start pulses in the same cycle as frame_pulse. Dumped-frame counter <= 0.
  - DUMP: each frame boundary increments the dumped counter. When DUMP_FRAMES!=0 and the incremented count == DUMP_FRAMES -> DONE, with dump_en<=0 and dump_stop pulsing in the same cycle as frame_pulse. DUMP_FRAMES=0 never exits on count.
  - DONE: hold, dump_en=0.
  - downloading=1 in any state -> WAIT_DL next cycle. If leaving DUMP, dump_en<=0 and dump_stop pulses once. This has priority over frame-boundary transitions in the same cycle.
- A frame boundary that both opens the window (START_FRAME) and would satisfy DUMP_FRAMES=1 opens only. Closing happens at the next boundary, so exactly one frame is dumped.
- rst mid-dump: all outputs return to reset values next cycle; no dump_stop pulse.
- dump_start and dump_stop are never high in the same cycle.

Test Plan:
- rst=1, 3 cycles, downloading=0, then release -> all outputs 0. FSM enters ARMED after 1 clk. First vs falling edge -> frame_cnt=1, frame_pulse 1 cycle.
- Video 8 pxl_cen per line, 6 lines per frame, START_FRAME=2, DUMP_FRAMES=3 -> dump_start with the 3rd frame_pulse (frame_cnt 2->3). dump_stop on the 6th frame_pulse (frame_cnt 5->6); dump_en high for exactly 3 frame periods. From the 2nd frame on, vlines=6 and hpixels=8.
- downloading=1 for 4 frames while in DUMP -> next cycle dump_en=0, dump_stop one pulse, frame_cnt=0 and stays 0 with frame_pulse still toggling. After downloading falls, window reopens at frame_cnt==START_FRAME.
- Force frame_cnt near wrap (START_FRAME=32'hFFFF_FFFF) -> dump_start on boundary where frame_cnt goes FFFF_FFFF->0.
- pxl_cen low for 50 clks mid-line -> no counts change; hpixels still reports line length in pxl_cen units.
- LW=3, 10 lines per frame -> vlines saturates at 7. Frame boundary coincident with an hs falling edge -> line counter restarts at 1.
